// File: rtl/player_health_if.sv
// Bundles the game-state, damage/heal event inputs and HP/status outputs
// between the gameplay logic and the player_health tracker.
interface player_health_if;
    logic [1:0] game_active;
    logic [1:0] char_class;
    logic [3:0] char_hp;
    logic       frame_tick;
    logic       dmg_valid;
    logic [3:0] dmg_amount;
    logic       heal_valid;
    logic [3:0] heal_amount;
    logic [3:0] current_hp;
    logic [3:0] max_hp;
    logic       player_dead;
    logic       invuln;
    logic       hit_flash;

    modport master (
        output game_active, char_class, char_hp, frame_tick,
               dmg_valid, dmg_amount, heal_valid, heal_amount,
        input  current_hp, max_hp, player_dead, invuln, hit_flash
    );

    modport slave (
        input  game_active, char_class, char_hp, frame_tick,
               dmg_valid, dmg_amount, heal_valid, heal_amount,
        output current_hp, max_hp, player_dead, invuln, hit_flash
    );
endinterface

// File: rtl/player_health.sv
// Player hit-point tracker: loads class HP at game start, applies damage/heal,
// and runs frame-counted invulnerability with a blinking hit flash.
module player_health #(
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned FLASH_FRAMES  = 4
) (
    input  logic           clk,
    input  logic           rst,
    player_health_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ALIVE, S_INVULN, S_DEAD} state_t;

    localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_FRAMES);

    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[4] ? 4'd0 : d[3:0];
    endfunction

    function automatic logic [3:0] clamp_add(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] lim);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[3:0];
    endfunction

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ga_prev;
    logic [3:0] r_cur_hp, w_cur_hp_nxt;
    logic [3:0] r_max_hp, w_max_hp_nxt;
    logic [7:0] r_inv_cnt, w_inv_cnt_nxt;
    logic [3:0] r_flash_cnt, w_flash_cnt_nxt;
    logic       r_flash_phase, w_flash_phase_nxt;
    logic       r_dead, r_invuln, r_hit_flash;
    logic       w_start;
    logic [3:0] w_hp_dmg;
    logic [3:0] w_hp_heal;

    assign w_start   = (r_ga_prev == 2'd0) && (bus.game_active == 2'd1);
    assign w_hp_dmg  = sat_sub(r_cur_hp, bus.dmg_amount);
    assign w_hp_heal = clamp_add(r_cur_hp, bus.heal_amount, r_max_hp);

    always_comb begin
        w_state_nxt       = r_state;
        w_cur_hp_nxt      = r_cur_hp;
        w_max_hp_nxt      = r_max_hp;
        w_inv_cnt_nxt     = r_inv_cnt;
        w_flash_cnt_nxt   = r_flash_cnt;
        w_flash_phase_nxt = r_flash_phase;
        case (bus.game_active)
            2'd0: begin
                w_state_nxt       = S_IDLE;
                w_cur_hp_nxt      = 4'd0;
                w_max_hp_nxt      = 4'd0;
                w_inv_cnt_nxt     = 8'd0;
                w_flash_cnt_nxt   = 4'd0;
                w_flash_phase_nxt = 1'b0;
            end
            2'd1: begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start && bus.char_class != 2'd0 && bus.char_hp != 4'd0) begin
                            w_state_nxt  = S_ALIVE;
                            w_cur_hp_nxt = bus.char_hp;
                            w_max_hp_nxt = bus.char_hp;
                        end
                    end
                    S_ALIVE: begin
                        // Damage takes priority; a heal in the same cycle is dropped.
                        if (bus.dmg_valid && bus.dmg_amount != 4'd0) begin
                            w_cur_hp_nxt = w_hp_dmg;
                            if (w_hp_dmg == 4'd0) begin
                                w_state_nxt = S_DEAD;
                            end else begin
                                w_state_nxt       = S_INVULN;
                                w_inv_cnt_nxt     = INV_LOAD;
                                w_flash_cnt_nxt   = FLASH_LOAD;
                                w_flash_phase_nxt = 1'b1;
                            end
                        end else if (bus.heal_valid) begin
                            w_cur_hp_nxt = w_hp_heal;
                        end
                    end
                    S_INVULN: begin
                        if (bus.heal_valid) begin
                            w_cur_hp_nxt = w_hp_heal;
                        end
                        if (bus.frame_tick) begin
                            if (r_inv_cnt <= 8'd1) begin
                                w_state_nxt       = S_ALIVE;
                                w_inv_cnt_nxt     = 8'd0;
                                w_flash_cnt_nxt   = 4'd0;
                                w_flash_phase_nxt = 1'b0;
                            end else begin
                                w_inv_cnt_nxt = r_inv_cnt - 8'd1;
                                if (r_flash_cnt <= 4'd1) begin
                                    w_flash_cnt_nxt   = FLASH_LOAD;
                                    w_flash_phase_nxt = ~r_flash_phase;
                                end else begin
                                    w_flash_cnt_nxt = r_flash_cnt - 4'd1;
                                end
                            end
                        end
                    end
                    S_DEAD: begin
                        w_cur_hp_nxt = 4'd0;
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
            default: begin
                // Game over / paused: everything holds.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ga_prev     <= 2'd0;
            r_cur_hp      <= 4'd0;
            r_max_hp      <= 4'd0;
            r_inv_cnt     <= 8'd0;
            r_flash_cnt   <= 4'd0;
            r_flash_phase <= 1'b0;
            r_dead        <= 1'b0;
            r_invuln      <= 1'b0;
            r_hit_flash   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ga_prev     <= bus.game_active;
            r_cur_hp      <= w_cur_hp_nxt;
            r_max_hp      <= w_max_hp_nxt;
            r_inv_cnt     <= w_inv_cnt_nxt;
            r_flash_cnt   <= w_flash_cnt_nxt;
            r_flash_phase <= w_flash_phase_nxt;
            r_dead        <= (w_state_nxt == S_DEAD);
            r_invuln      <= (w_state_nxt == S_INVULN);
            r_hit_flash   <= (w_state_nxt == S_INVULN) && w_flash_phase_nxt;
        end
    end

    assign bus.current_hp  = r_cur_hp;
    assign bus.max_hp      = r_max_hp;
    assign bus.player_dead = r_dead;
    assign bus.invuln      = r_invuln;
    assign bus.hit_flash   = r_hit_flash;
endmodule

// File: tb/tb_player_health.sv
// Bench for player_health: directed vector table, hand-written invulnerability
// and pause sequences, then random traffic against a behavioural model.
module tb_player_health;
    localparam int INV = 60;
    localparam int FL  = 4;

    logic clk = 1'b0;
    logic rst;
    player_health_if bus();

    player_health #(.INVULN_FRAMES(INV), .FLASH_FRAMES(FL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r, ga, cls, chp, ft, dv, da, hv, ha;
        int hp, mx, dead, inv, fl;
    } vec_t;

    vec_t tbl [0:20];
    int   n_chk = 0;
    int   n_err = 0;

    int c_r, c_ga, c_cls, c_chp, c_ft, c_dv, c_da, c_hv, c_ha;

    // Behavioural model state
    int m_ga_prev, m_hp, m_max, m_inv_left, m_ticks;
    bit m_started, m_dead;

    task automatic drive(input int r, input int ga, input int cls, input int chp, input int ft,
                         input int dv, input int da, input int hv, input int ha);
        c_r = r; c_ga = ga; c_cls = cls; c_chp = chp; c_ft = ft;
        c_dv = dv; c_da = da; c_hv = hv; c_ha = ha;
        rst             = r[0];
        bus.game_active = 2'(ga);
        bus.char_class  = 2'(cls);
        bus.char_hp     = 4'(chp);
        bus.frame_tick  = ft[0];
        bus.dmg_valid   = dv[0];
        bus.dmg_amount  = 4'(da);
        bus.heal_valid  = hv[0];
        bus.heal_amount = 4'(ha);
    endtask

    task automatic check(input string nm, input int hp, input int mx, input int dead,
                         input int inv, input int fl);
        logic [10:0] act, exp;
        act = {bus.current_hp, bus.max_hp, bus.player_dead, bus.invuln, bus.hit_flash};
        exp = {4'(hp), 4'(mx), dead[0], inv[0], fl[0]};
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got hp=%0d max=%0d dead=%b inv=%b flash=%b, want hp=%0d max=%0d dead=%b inv=%b flash=%b",
                     nm, act[10:7], act[6:3], act[2], act[1], act[0],
                     exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_started = 0; m_dead = 0; m_hp = 0; m_max = 0; m_inv_left = 0; m_ticks = 0;
    endtask

    task automatic model_step();
        if (c_r != 0) begin
            model_clear();
            m_ga_prev = 0;
        end else begin
            if (c_ga == 0) begin
                model_clear();
            end else if (c_ga == 1) begin
                if (!m_started) begin
                    if (m_ga_prev == 0 && c_cls != 0 && c_chp != 0) begin
                        m_started = 1; m_hp = c_chp; m_max = c_chp;
                    end
                end else if (!m_dead) begin
                    if (m_inv_left == 0 && c_dv != 0 && c_da != 0) begin
                        if (m_hp - c_da <= 0) begin
                            m_dead = 1; m_hp = 0;
                        end else begin
                            m_hp = m_hp - c_da; m_inv_left = INV; m_ticks = 0;
                        end
                    end else begin
                        if (c_hv != 0) m_hp = (m_hp + c_ha > m_max) ? m_max : m_hp + c_ha;
                        if (m_inv_left > 0 && c_ft != 0) begin
                            m_inv_left--; m_ticks++;
                        end
                    end
                end
            end
            m_ga_prev = c_ga;
        end
    endtask

    task automatic tick_once();
        drive(0, 1, 1, 10, 1, 0, 0, 0, 0); cyc();
    endtask

    task automatic quiet_once(input int ga);
        drive(0, ga, 1, 10, 0, 0, 0, 0, 0); cyc();
    endtask

    initial begin
        //              r ga cls chp ft dv da hv ha   hp mx dd in fl
        tbl[0]  = '{1, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 10, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 10, 0, 0, 0, 0, 0,  10,10, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 10, 0, 1, 3, 0, 0,   7,10, 0, 1, 1};
        tbl[4]  = '{0, 1, 1, 10, 0, 1, 5, 0, 0,   7,10, 0, 1, 1};
        tbl[5]  = '{0, 1, 1, 10, 0, 0, 0, 1, 2,   9,10, 0, 1, 1};
        tbl[6]  = '{0, 1, 1, 10, 0, 1, 0, 0, 0,   9,10, 0, 1, 1};
        tbl[7]  = '{0, 0, 1, 10, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 10, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 2,  8, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 2,  8, 0, 0, 0, 0, 0,   8, 8, 0, 0, 0};
        tbl[11] = '{0, 1, 2,  8, 0, 1, 0, 0, 0,   8, 8, 0, 0, 0};
        tbl[12] = '{0, 1, 2,  8, 0, 1, 2, 1, 4,   6, 8, 0, 1, 1};
        tbl[13] = '{0, 3, 2,  8, 0, 1, 5, 0, 0,   6, 8, 0, 1, 1};
        tbl[14] = '{0, 3, 2,  8, 1, 0, 0, 0, 0,   6, 8, 0, 1, 1};
        tbl[15] = '{0, 1, 2,  8, 0, 0, 0, 1, 9,   8, 8, 0, 1, 1};
        tbl[16] = '{1, 1, 2,  8, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[17] = '{0, 1, 2,  8, 0, 0, 0, 0, 0,   8, 8, 0, 0, 0};
        tbl[18] = '{0, 1, 2,  8, 0, 1,15, 0, 0,   0, 8, 1, 0, 0};
        tbl[19] = '{0, 1, 2,  8, 0, 0, 0, 1, 5,   0, 8, 1, 0, 0};
        tbl[20] = '{0, 0, 2,  8, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 20; i++) begin
            drive(tbl[i].r, tbl[i].ga, tbl[i].cls, tbl[i].chp, tbl[i].ft,
                  tbl[i].dv, tbl[i].da, tbl[i].hv, tbl[i].ha);
            cyc();
            check($sformatf("vec%0d", i), tbl[i].hp, tbl[i].mx, tbl[i].dead, tbl[i].inv, tbl[i].fl);
        end

        // Full invulnerability window; the tick on the hit cycle must not count.
        quiet_once(0);
        drive(0, 1, 1, 10, 0, 0, 0, 0, 0); cyc();
        check("win_start", 10, 10, 0, 0, 0);
        drive(0, 1, 1, 10, 1, 1, 3, 0, 0); cyc();
        check("win_hit", 7, 10, 0, 1, 1);
        for (int k = 1; k <= INV; k++) begin
            tick_once();
            check($sformatf("win_tick%0d", k), 7, 10, 0, (k < INV) ? 1 : 0,
                  (k < INV && ((k / FL) % 2) == 0) ? 1 : 0);
            quiet_once(1);
        end
        drive(0, 1, 1, 10, 0, 0, 0, 1, 2); cyc();
        check("win_heal_alive", 9, 10, 0, 0, 0);

        // Pause freezes the countdown and blocks damage.
        quiet_once(0);
        quiet_once(1);
        drive(0, 1, 1, 10, 0, 1, 3, 0, 0); cyc();
        for (int k = 1; k <= 10; k++) begin
            tick_once(); quiet_once(1);
        end
        check("pause_pre", 7, 10, 0, 1, 1);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 3, 1, 10, 1, 0, 0, 0, 0); cyc();
            quiet_once(3);
        end
        drive(0, 3, 1, 10, 0, 1, 5, 0, 0); cyc();
        check("pause_dmg", 7, 10, 0, 1, 1);
        for (int k = 1; k <= INV - 10; k++) begin
            tick_once();
            if (k == INV - 11) check("resume_last_in", 7, 10, 0, 1, (((k + 10) / FL) % 2 == 0) ? 1 : 0);
            if (k == INV - 10) check("resume_end", 7, 10, 0, 0, 0);
            quiet_once(1);
        end

        // Random traffic against the behavioural model.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); model_step(); #1;
        check("rand_reset", 0, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            int p, ga;
            p = int'($urandom_range(0, 99));
            ga = (p < 1) ? 0 : (p < 3) ? 2 : (p < 5) ? 3 : 1;
            drive(($urandom_range(0, 299) == 0) ? 1 : 0, ga,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0) ? 1 : 0, int'($urandom_range(0, 15)));
            @(posedge clk);
            model_step();
            #1;
            check("rand", m_hp, m_max, m_dead ? 1 : 0, (m_inv_left > 0) ? 1 : 0,
                  (m_inv_left > 0 && ((m_ticks / FL) % 2) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/player_health.md
# player_health

Tracks the player's hit points once a class has been chosen on the menu screen. Downstream of class selection, it loads the starting HP from `char_hp` when play begins. It then applies damage and heal events with frame-counted invulnerability after each hit. It drives HP, death and hit-flash status to the HUD renderer, the player sprite renderer and the game-state controller.

## Interface
- `INVULN_FRAMES`, default 60: frames of invulnerability after a non-lethal hit; must be 1..255.
- `FLASH_FRAMES`, default 4: frames per half-period of the hit-flash blink; must be 1..15.
- `clk`  in  1  system (pixel) clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `game_active`  in  2  game state: 0 = menu, 1 = playing, 2 = game over, 3 = paused.
- `char_class`  in  2  selected class: 0 = none, 1 = melee, 2 = archer.
- `char_hp`  in  4  starting/max HP for the selected class.
- `frame_tick`  in  1  one-cycle pulse per video frame (start of vblank).
- `dmg_valid`  in  1  one-cycle damage event.
- `dmg_amount`  in  4  damage value, sampled when `dmg_valid` = 1.
- `heal_valid`  in  1  one-cycle heal event.
- `heal_amount`  in  4  heal value, sampled when `heal_valid` = 1.
- `current_hp`  out  4  present HP.
- `max_hp`  out  4  HP latched at game start.
- `player_dead`  out  1  high while in DEAD.
- `invuln`  out  1  high while in INVULN.
- `hit_flash`  out  1  blink enable for the sprite renderer; high only in INVULN.

## Operation
- The FSM has four states: IDLE, ALIVE, INVULN, DEAD. All outputs are registered.
- `game_active` is registered each cycle as `ga_prev`. Start event = `ga_prev` == 0 and `game_active` == 1.
- IDLE:
  - All outputs are 0.
  - On a start event with `char_class` != 0 and `char_hp` != 0: `max_hp` and `current_hp` load `char_hp`, then go to ALIVE.
  - On a start event with no class selected: stay in IDLE.
- `game_active` == 0 in any state: go to IDLE next cycle and clear all outputs and counters.
- `game_active` == 2 or 3: the FSM is frozen. The state, HP and counters hold. `dmg_valid`, `heal_valid` and `frame_tick` are ignored.
- ALIVE, on `dmg_valid` with `dmg_amount` != 0:
  - `hp_next` = `current_hp` − `dmg_amount`, computed 5-bit and saturated at 0.
  - If `hp_next` == 0: go to DEAD.
  - Otherwise go to INVULN, load `inv_cnt` = `INVULN_FRAMES`, load `flash_cnt` = `FLASH_FRAMES`, and set `flash_phase` = 1.
- `dmg_valid` with `dmg_amount` == 0 is a no-op: no state change and no invulnerability.
- INVULN:
  - Damage is ignored.
  - On each `frame_tick`, `inv_cnt` decrements. When it would reach 0, go to ALIVE.
  - `flash_cnt` decrements on each `frame_tick`. When it reaches 0, reload it with `FLASH_FRAMES` and toggle `flash_phase`.
  - `hit_flash` = `flash_phase`.
- Heal is accepted in ALIVE and INVULN only:
  - `current_hp` = min(`current_hp` + `heal_amount`, `max_hp`), computed 5-bit.
  - Heal does not change the state and does not affect the invulnerability counter.
- Damage and heal in the same cycle (ALIVE): damage wins and the heal is dropped.
- In INVULN, damage is ignored, so a simultaneous heal is applied.
- DEAD:
  - `current_hp` = 0 and `player_dead` = 1. Heals are ignored.
  - DEAD is left only via `game_active` == 0, or via `rst`.

## Timing
- Reset values: every output 0, FSM in IDLE, `ga_prev` = 0, all counters 0.
- Latency is 1 cycle: any event sampled on edge N is visible on the outputs after edge N (in cycle N+1).
- Start event: `current_hp` = `max_hp` = `char_hp` one cycle after the cycle in which `game_active` first reads 1.
- A non-lethal hit on cycle N: `invuln` = 1 and `hit_flash` = 1 from cycle N+1.
- Invulnerability lasts exactly `INVULN_FRAMES` `frame_tick` pulses. `invuln` falls the cycle after the last pulse.
- A `frame_tick` coincident with the hit cycle is not counted.
- `rst` asserted mid-operation overrides everything on the next edge.
- Pulses are single-cycle. Holding `dmg_valid` high in ALIVE applies damage once, then it is ignored in INVULN.

## Test plan
- Reset, then `game_active` 0→1 with `char_class` = 1, `char_hp` = 10 → next cycle `current_hp` = 10, `max_hp` = 10, ALIVE.
- From 10 HP, damage 3 → `current_hp` = 7, `invuln` = 1. A second damage of 5 inside the window → ignored, HP stays 7. After 60 `frame_tick`s → `invuln` = 0. `hit_flash` toggles every 4 ticks during the window.
- From 7 HP, damage 15 → `current_hp` = 0, `player_dead` = 1. A later heal of 5 → still 0 and dead. `game_active` → 0 → all outputs 0.
- Archer start (`char_hp` = 8), damage 2 → 6. Heal 9 → `current_hp` = 8 (clamped). Damage 2 and heal 4 in the same ALIVE cycle → 6.
- `game_active` = 3 during INVULN with 5 `frame_tick`s → `inv_cnt` and HP unchanged. A damage pulse while paused → ignored. Back to 1 → countdown resumes.
- Start event with `char_class` = 0 → stays IDLE, outputs 0. `dmg_valid` with amount 0 in ALIVE → no change. `rst` mid-INVULN → all outputs 0 next cycle.
